// File: rtl/ln_op_sequencer.sv
// Streams operands from a small FIFO through one LINEALIZADOR ln unit: reset, load, begin, wait ack, hold result.
// Optional WAIT abort counter is built only when LN_SEQ_TIMEOUT_EN is defined; otherwise out_to is tied low.
module ln_op_sequencer #(
   parameter int P       = 32,
   parameter int DEPTH   = 4,
   parameter int RST_CYC = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_vld,
   output logic                   in_rdy,
   input  logic [P-1:0]           in_t,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [P-1:0]           out_result,
   output logic                   out_of,
   output logic                   out_uf,
   output logic                   out_to,
   output logic                   ln_rst,
   output logic                   ln_begin,
   output logic [P-1:0]           ln_t,
   input  logic                   ln_ack,
   input  logic [P-1:0]           ln_result,
   input  logic                   ln_of,
   input  logic                   ln_uf,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_lvl
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_HOLD
   } state_t;

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RST_CYC < 1 || TIMEOUT < 1) begin : g_cfg_check
         $error("ln_op_sequencer: illegal DEPTH/RST_CYC/TIMEOUT");
      end
   endgenerate

   state_t          state_r, state_s;
   logic [P-1:0]    mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [LW-1:0]   lvl_r, lvl_next_s;
   logic            in_rdy_r;
   logic            push_s, pop_s, wait_exit_s;
   logic [P-1:0]    op_r;
   logic [CW-1:0]   clr_cnt_r;
   logic            ln_rst_r, ln_begin_r, busy_r;
   logic [P-1:0]    ln_t_r, out_result_r;
   logic            out_vld_r, out_of_r, out_uf_r;

   assign push_s      = in_vld && in_rdy_r;
   assign pop_s       = (state_r == S_IDLE) && (lvl_r != '0);
   assign wait_exit_s = (state_r == S_WAIT) && (state_s == S_CAPTURE);

   // FIFO occupancy after this cycle's push/pop
   always_comb begin
      lvl_next_s = lvl_r;
      case ({push_s, pop_s})
         2'b10:   lvl_next_s = lvl_r + LW'(1);
         2'b01:   lvl_next_s = lvl_r - LW'(1);
         default: lvl_next_s = lvl_r;
      endcase
   end

   // FIFO storage; emptiness is tracked by the level, so no reset needed
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_t;
      end
   end

   // FIFO pointers, level and registered ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         lvl_r    <= '0;
         in_rdy_r <= 1'b1;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         lvl_r    <= lvl_next_s;
         in_rdy_r <= (lvl_next_s != LW'(DEPTH));
      end
   end

`ifdef LN_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt_r;
   logic          to_hit_s;

   // WAIT-cycle counter; zero outside WAIT so it restarts on every entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_r <= '0;
      end else if (state_r == S_WAIT) begin
         to_cnt_r <= to_cnt_r + TW'(1);
      end else begin
         to_cnt_r <= '0;
      end
   end
`endif

   // Next-state logic
   always_comb begin
      state_s = state_r;
`ifdef LN_SEQ_TIMEOUT_EN
      to_hit_s = 1'b0;
`endif
      case (state_r)
         S_IDLE: begin
            if (lvl_r != '0) state_s = S_CLR;
            else             state_s = S_IDLE;
         end
         S_CLR: begin
            if (clr_cnt_r == CW'(RST_CYC - 1)) state_s = S_LOAD;
            else                               state_s = S_CLR;
         end
         S_LOAD:  state_s = S_START;
         S_START: state_s = S_WAIT;
         S_WAIT: begin
            // an ack in the final counted cycle still wins over the timeout
            if (ln_ack) begin
               state_s = S_CAPTURE;
            end
`ifdef LN_SEQ_TIMEOUT_EN
            else if (to_cnt_r == TW'(TIMEOUT - 1)) begin
               state_s  = S_CAPTURE;
               to_hit_s = 1'b1;
            end
`endif
            else begin
               state_s = S_WAIT;
            end
         end
         S_CAPTURE: state_s = S_HOLD;
         S_HOLD: begin
            if (out_rdy) state_s = S_IDLE;
            else         state_s = S_HOLD;
         end
         default: state_s = S_IDLE;
      endcase
   end

   // State register and registered unit-side controls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         op_r       <= '0;
         clr_cnt_r  <= '0;
         ln_rst_r   <= 1'b1;
         ln_begin_r <= 1'b0;
         ln_t_r     <= '0;
         busy_r     <= 1'b0;
      end else begin
         state_r <= state_s;
         if (pop_s) op_r <= mem_r[rd_ptr_r];
         if (state_r == S_CLR) clr_cnt_r <= clr_cnt_r + CW'(1);
         else                  clr_cnt_r <= '0;
         ln_rst_r   <= (state_s == S_IDLE) || (state_s == S_CLR);
         ln_begin_r <= (state_s == S_START);
         if (state_s == S_LOAD) ln_t_r <= op_r;
         busy_r     <= (state_s != S_IDLE);
      end
   end

   // Result sampled on the ack edge itself, since RESULT is only qualified by ACK
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_r    <= 1'b0;
         out_result_r <= '0;
         out_of_r     <= 1'b0;
         out_uf_r     <= 1'b0;
      end else begin
         out_vld_r <= (state_s == S_HOLD);
         if (wait_exit_s) begin
`ifdef LN_SEQ_TIMEOUT_EN
            if (to_hit_s) begin
               out_result_r <= '0;
               out_of_r     <= 1'b0;
               out_uf_r     <= 1'b0;
            end else begin
               out_result_r <= ln_result;
               out_of_r     <= ln_of;
               out_uf_r     <= ln_uf;
            end
`else
            out_result_r <= ln_result;
            out_of_r     <= ln_of;
            out_uf_r     <= ln_uf;
`endif
         end
      end
   end

`ifdef LN_SEQ_TIMEOUT_EN
   logic out_to_r;

   // Timeout flag captured alongside the result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_to_r <= 1'b0;
      end else if (wait_exit_s) begin
         out_to_r <= to_hit_s;
      end else begin
         out_to_r <= out_to_r;
      end
   end
   assign out_to = out_to_r;
`else
   assign out_to = 1'b0;
`endif

   assign in_rdy     = in_rdy_r;
   assign out_vld    = out_vld_r;
   assign out_result = out_result_r;
   assign out_of     = out_of_r;
   assign out_uf     = out_uf_r;
   assign ln_rst     = ln_rst_r;
   assign ln_begin   = ln_begin_r;
   assign ln_t       = ln_t_r;
   assign busy       = busy_r;
   assign fifo_lvl   = lvl_r;

endmodule

// File: tb/tb_ln_op_sequencer.sv
// Directed bench for ln_op_sequencer with a stub LINEALIZADOR that acks a programmable number of cycles after Begin.
// Timeout sequence is compiled in only when LN_SEQ_TIMEOUT_EN is defined.
module tb_ln_op_sequencer;

   localparam int P       = 32;
   localparam int DEPTH   = 4;
   localparam int RST_CYC = 2;
   localparam int TIMEOUT = 1023;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_vld = 1'b0;
   logic          in_rdy;
   logic [P-1:0]  in_t = '0;
   logic          out_vld;
   logic          out_rdy = 1'b0;
   logic [P-1:0]  out_result;
   logic          out_of, out_uf, out_to;
   logic          ln_rst, ln_begin;
   logic [P-1:0]  ln_t;
   logic          ln_ack;
   logic [P-1:0]  ln_result;
   logic          ln_of, ln_uf;
   logic          busy;
   logic [2:0]    fifo_lvl;

   int n_tot  = 0;
   int n_pass = 0;
   int ack_dly = 0;
   int ack_cnt = 0;
   int begin_cnt = 0;
   logic [31:0] junk_r = 32'h1234_5678;

   ln_op_sequencer #(.P(P), .DEPTH(DEPTH), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_t(in_t),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_result(out_result),
      .out_of(out_of), .out_uf(out_uf), .out_to(out_to),
      .ln_rst(ln_rst), .ln_begin(ln_begin), .ln_t(ln_t), .ln_ack(ln_ack),
      .ln_result(ln_result), .ln_of(ln_of), .ln_uf(ln_uf),
      .busy(busy), .fifo_lvl(fifo_lvl)
   );

   always #5 clk = ~clk;

   // stub ln unit: result/flags are only meaningful while ack is high
   function automatic logic [31:0] stub_res(input logic [31:0] t);
      if (t == 32'h3F00_0000) return 32'hBF31_7218;
      return {~t[31], t[30:0]} ^ 32'h0000_1234;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)            ack_cnt <= 0;
      else if (ln_begin)     ack_cnt <= 1;
      else if (ack_cnt != 0) ack_cnt <= (ack_cnt == ack_dly) ? 0 : ack_cnt + 1;
   end

   always @(posedge clk) junk_r <= {junk_r[30:0], ~junk_r[31]} ^ 32'h0000_0005;
   always @(negedge clk) if (ln_begin) begin_cnt <= begin_cnt + 1;

   assign ln_ack    = (ack_dly != 0) && (ack_cnt == ack_dly);
   assign ln_result = ln_ack ? stub_res(ln_t) : junk_r;
   assign ln_of     = ln_ack ? (ln_t == 32'h0000_0000) : junk_r[0];
   assign ln_uf     = ln_ack ? (ln_t == 32'h0080_0000) : junk_r[1];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic push(input logic [31:0] t);
      int g;
      g = 0;
      @(negedge clk);
      while (!in_rdy && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (!in_rdy) chk("push_rdy", 32'(in_rdy), 32'd1);
      in_vld = 1'b1;
      in_t   = t;
      @(posedge clk);
      #1 in_vld = 1'b0;
   endtask

   task automatic wait_vld(output int lat, input int bound);
      lat = 0;
      while (lat < bound) begin
         @(posedge clk);
         #1 lat++;
         if (out_vld) return;
      end
   endtask

   task automatic accept();
      @(negedge clk);
      out_rdy = 1'b1;
      @(posedge clk);
      #1 out_rdy = 1'b0;
      chk("accept_vld_low", 32'(out_vld), 32'd0);
   endtask

   typedef struct {
      logic [31:0] t;
      int          dly;
      logic [31:0] exp_res;
      logic        exp_of;
      logic        exp_uf;
      int          exp_lat;
   } vec_t;

   vec_t vecs[4];
   logic [31:0] exp_q[5];

   initial begin
      int lat, b0, n_res, bad, seen;
      logic [31:0] held;

      vecs[0] = '{32'h3F00_0000, 20, 32'hBF31_7218, 1'b0, 1'b0, 26};
      vecs[1] = '{32'h0000_0000,  5, 32'h8000_1234, 1'b1, 1'b0, 11};
      vecs[2] = '{32'h0080_0000,  1, 32'h8080_1234, 1'b0, 1'b1,  7};
      vecs[3] = '{32'h3F80_0000,  3, 32'hBF80_1234, 1'b0, 1'b0,  9};
      exp_q   = '{32'hC000_1234, 32'hC040_1234, 32'hC080_1234, 32'hC0A0_1234, 32'hC0C0_1234};

      // reset values
      #12;
      chk("rst_in_rdy",   32'(in_rdy),   32'd1);
      chk("rst_out_vld",  32'(out_vld),  32'd0);
      chk("rst_result",   out_result,    32'd0);
      chk("rst_flags",    {29'd0, out_of, out_uf, out_to}, 32'd0);
      chk("rst_ln_rst",   32'(ln_rst),   32'd1);
      chk("rst_ln_begin", 32'(ln_begin), 32'd0);
      chk("rst_ln_t",     ln_t,          32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_lvl",      32'(fifo_lvl), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("idle_ln_rst", 32'(ln_rst), 32'd1);

      // single operations: latency, result, flags, one Begin pulse each
      for (int i = 0; i < 4; i++) begin
         ack_dly = vecs[i].dly;
         b0 = begin_cnt;
         push(vecs[i].t);
         wait_vld(lat, 200);
         chk("vec_lat",    lat,                 vecs[i].exp_lat);
         chk("vec_result", out_result,          vecs[i].exp_res);
         chk("vec_of",     32'(out_of),         32'(vecs[i].exp_of));
         chk("vec_uf",     32'(out_uf),         32'(vecs[i].exp_uf));
         chk("vec_to",     32'(out_to),         32'd0);
         chk("vec_ln_t",   ln_t,                vecs[i].t);
         chk("vec_begins", begin_cnt - b0,      32'd1);
         accept();
      end

      // FIFO full with output stalled, then in-order drain
      ack_dly = 4;
      for (int i = 0; i < 5; i++) push(exp_q[i] ^ 32'h8000_1234);
      chk("full_in_rdy", 32'(in_rdy),   32'd0);
      chk("full_lvl",    32'(fifo_lvl), 32'd4);
      chk("full_busy",   32'(busy),     32'd1);
      @(negedge clk);
      out_rdy = 1'b1;
      n_res = 0;
      for (int c = 0; c < 400; c++) begin
         if (out_vld) begin
            if (n_res < 5) chk("full_order", out_result, exp_q[n_res]);
            n_res++;
         end
         @(posedge clk);
         #1;
      end
      out_rdy = 1'b0;
      chk("full_count", n_res, 32'd5);
      chk("drain_lvl",  32'(fifo_lvl), 32'd0);

      // backpressure: result frozen and no new Begin while HOLD is stalled
      ack_dly = 2;
      push(32'h3F00_0000);
      push(32'h4000_0000);
      wait_vld(lat, 100);
      chk("bp_vld", 32'(out_vld), 32'd1);
      held = out_result;
      chk("bp_result", held, 32'hBF31_7218);
      b0 = begin_cnt;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1 if (out_result !== held || !out_vld) bad++;
      end
      chk("bp_stable", bad, 32'd0);
      chk("bp_no_begin", begin_cnt - b0, 32'd0);
      chk("bp_lvl", 32'(fifo_lvl), 32'd1);
      accept();
      wait_vld(lat, 100);
      chk("bp_second", out_result, 32'hC000_1234);
      accept();

`ifdef LN_SEQ_TIMEOUT_EN
      // timeout abort, then the next operand completes normally
      ack_dly = 0;
      push(32'h3F00_0000);
      wait_vld(lat, 1200);
      chk("to_lat",    lat,              32'd1029);
      chk("to_flag",   32'(out_to),      32'd1);
      chk("to_result", out_result,       32'd0);
      chk("to_flags",  {30'd0, out_of, out_uf}, 32'd0);
      push(32'h3F80_0000);
      ack_dly = 3;
      accept();
      wait_vld(lat, 100);
      chk("to_next_result", out_result,  32'hBF80_1234);
      chk("to_next_flag",   32'(out_to), 32'd0);
      accept();
`endif

      // asynchronous reset while waiting with three operands queued
      ack_dly = 0;
      for (int i = 0; i < 4; i++) push(32'h4100_0000 + 32'(i));
      chk("mid_lvl", 32'(fifo_lvl), 32'd3);
      repeat (10) @(posedge clk);
      #1 chk("mid_ln_rst_low", 32'(ln_rst), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_out_vld", 32'(out_vld),  32'd0);
      chk("mid_lvl_clr", 32'(fifo_lvl), 32'd0);
      chk("mid_ln_rst",  32'(ln_rst),   32'd1);
      chk("mid_busy",    32'(busy),     32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      ack_dly = 3;
      out_rdy = 1'b1;
      b0 = begin_cnt;
      seen = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #1 if (out_vld) seen++;
      end
      chk("post_rst_no_result", seen, 32'd0);
      chk("post_rst_no_begin",  begin_cnt - b0, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
